// File: rtl/ice40_ram_reader_pkg.sv
// Shared types and constants for the iCE40 256x16 block-RAM read controller.
package ice40_ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int RAM_DEPTH = 256;
  localparam int RAM_AW    = 8;
  localparam int BUF_DEPTH = 2;
  localparam int LEN_W     = $clog2(RAM_DEPTH) + 1;

  // A read may be issued only if the word it returns is guaranteed a buffer
  // slot. Words already buffered and the word still in flight both hold
  // slots. A pop in this cycle frees one slot.
  function automatic logic has_credit(input logic [1:0] occ,
                                      input logic       inflight,
                                      input logic       pop);
    logic [2:0] used;
    logic [2:0] avail;
    used  = {1'b0, occ} + {2'b00, inflight};
    avail = 3'(BUF_DEPTH) + {2'b00, pop};
    return (used < avail);
  endfunction

endpackage

// File: rtl/ice40_ram_reader_buf.sv
// Two-entry FIFO. The oldest word sits in a head register so the stream
// data comes straight from a flop and holds still while stalled.
module ice40_ram_reader_buf
  import ice40_ram_reader_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    occ_o
);

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    occ_q;
  logic          pop_s;

  assign pop_s  = pop_i && (occ_q != 2'd0);
  assign head_o = head_q;
  assign occ_o  = occ_q;

  // Move words through head/tail and track occupancy on push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= {DW{1'b0}};
      tail_q <= {DW{1'b0}};
      occ_q  <= 2'd0;
    end else begin
      case ({push_i, pop_s})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= data_i;
            occ_q  <= 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_q <= data_i;
            occ_q  <= FULL;
          end else begin
            // Full: the credit rule upstream keeps this from happening.
            occ_q <= occ_q;
          end
        end
        2'b01: begin
          if (occ_q == FULL) begin
            head_q <= tail_q;
            occ_q  <= 2'd1;
          end else begin
            occ_q <= occ_q - 2'd1;
          end
        end
        2'b11: begin
          // Pop and push together: occupancy is unchanged.
          if (occ_q == FULL) begin
            head_q <= tail_q;
            tail_q <= data_i;
          end else begin
            head_q <= data_i;
          end
        end
        default: begin
          occ_q <= occ_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/ice40_ram_reader.sv
// Burst read controller for an SB_RAM40_4K in 256x16 mode. It turns a
// (base, length) command into RAM reads and a valid/ready stream with LAST.
module ice40_ram_reader
  import ice40_ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESETN,
  input  logic                  START,
  input  logic [RAM_AW-1:0]     BASE,
  input  logic [LEN_W-1:0]      LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic                  RE,
  output logic                  RCLKE,
  input  logic [DATA_WIDTH-1:0] RDATA,
  output logic                  VALID,
  input  logic                  READY,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  LAST
);

  state_e              state_q;
  logic [RAM_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    issue_cnt_q;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic                inflight_q;
  logic                done_q;

  logic [1:0]          occ_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                pop_s;
  logic                issue_s;

  assign VALID   = (occ_s != 2'd0);
  assign DATA    = head_s;
  assign pop_s   = VALID && READY;
  assign LAST    = VALID && (beat_cnt_q == LEN_W'(1));
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign issue_s = (state_q == RUN) && has_credit(occ_s, inflight_q, pop_s);
  assign RE      = issue_s;
  assign RCLKE   = issue_s;
  assign RADDR   = issue_s ? {{(ADDR_WIDTH-RAM_AW){1'b0}}, addr_q}
                           : {ADDR_WIDTH{1'b0}};

  // Sequencer: command capture, address/count stepping and completion pulse.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= IDLE;
      addr_q      <= {RAM_AW{1'b0}};
      issue_cnt_q <= {LEN_W{1'b0}};
      beat_cnt_q  <= {LEN_W{1'b0}};
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue_s;
      if (pop_s) begin
        beat_cnt_q <= beat_cnt_q - LEN_W'(1);
      end
      if (issue_s) begin
        addr_q      <= addr_q + 8'd1;
        issue_cnt_q <= issue_cnt_q - LEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (START) begin
            if (LEN != {LEN_W{1'b0}}) begin
              addr_q      <= BASE;
              issue_cnt_q <= LEN;
              beat_cnt_q  <= LEN;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue_s && (issue_cnt_q == LEN_W'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_s && (beat_cnt_q == LEN_W'(1))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  ice40_ram_reader_buf #(
    .DW(DATA_WIDTH)
  ) u_buf (
    .clk_i  (CLK),
    .rst_ni (ASYNCRESETN),
    .push_i (inflight_q),
    .data_i (RDATA),
    .pop_i  (pop_s),
    .head_o (head_s),
    .occ_o  (occ_s)
  );

endmodule

// File: tb/tb_ice40_ram_reader.sv
// Scoreboard bench for ice40_ram_reader with a behavioural 256x16 RAM.
module tb_ice40_ram_reader;

  logic        CLK;
  logic        ASYNCRESETN;
  logic        START;
  logic [7:0]  BASE;
  logic [8:0]  LEN;
  logic        BUSY;
  logic        DONE;
  logic [10:0] RADDR;
  logic        RE;
  logic        RCLKE;
  logic [15:0] RDATA;
  logic        VALID;
  logic        READY;
  logic [15:0] DATA;
  logic        LAST;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [15:0] mem [0:255];
  logic [16:0] exp_q [$];
  logic        ready_mode = 1'b0;
  logic [3:0]  ready_pat  = 4'b1001;
  int          rp = 0;

  ice40_ram_reader dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .START       (START),
    .BASE        (BASE),
    .LEN         (LEN),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RADDR       (RADDR),
    .RE          (RE),
    .RCLKE       (RCLKE),
    .RDATA       (RDATA),
    .VALID       (VALID),
    .READY       (READY),
    .DATA        (DATA),
    .LAST        (LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM read port: registered data, one cycle after the enable.
  initial RDATA = 16'h0000;
  always @(posedge CLK) begin
    if (RCLKE) RDATA <= mem[RADDR[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // READY: constant high, or the repeating 1,0,0,1 pattern.
  initial begin
    READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (ready_mode) begin
        READY = ready_pat[rp];
        rp = (rp + 1) % 4;
      end else begin
        READY = 1'b1;
      end
    end
  end

  // Monitor: pop the scoreboard on every transfer, and check a stalled word
  // already equals the word that is due next.
  always @(negedge CLK) begin
    logic [16:0] e;
    if (ASYNCRESETN) begin
      if (VALID && !READY && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("stall_data", {16'h0, DATA}, {16'h0, e[15:0]});
      end
      if (VALID && READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got %0h expected none", DATA);
        end else begin
          e = exp_q.pop_front();
          chk("data", {16'h0, DATA}, {16'h0, e[15:0]});
          chk("last", {31'h0, LAST}, {31'h0, e[16]});
        end
        pops++;
      end
    end
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"},  {31'h0, BUSY},  32'h0);
    chk({tag, "_done"},  {31'h0, DONE},  32'h0);
    chk({tag, "_re"},    {31'h0, RE},    32'h0);
    chk({tag, "_rclke"}, {31'h0, RCLKE}, 32'h0);
    chk({tag, "_raddr"}, {21'h0, RADDR}, 32'h0);
    chk({tag, "_valid"}, {31'h0, VALID}, 32'h0);
    chk({tag, "_last"},  {31'h0, LAST},  32'h0);
    chk({tag, "_data"},  {16'h0, DATA},  32'h0);
  endtask

  // Issue one burst, then follow it to DONE. exp_k is the expected DONE
  // cycle counted from the START sampling edge (-1 = not checked).
  task automatic run_burst(input logic [7:0] base, input logic [8:0] len,
                           input int exp_k, input bit poke);
    int k;
    int re_cnt;
    bit got;
    logic [7:0] ea;
    for (int i = 0; i < int'(len); i++) begin
      ea = base + 8'(i);
      exp_q.push_back({(i == int'(len) - 1), mem[ea]});
    end
    @(posedge CLK); #1;
    BASE = base; LEN = len; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    k = 0; re_cnt = 0; got = 1'b0;
    while (!got && k < 2000) begin
      @(negedge CLK);
      k++;
      if (k == 1) chk("busy_first", {31'h0, BUSY}, {31'h0, (len != 9'd0)});
      if (RE) begin
        ea = base + 8'(re_cnt);
        chk("raddr", {21'h0, RADDR}, {24'h0, ea});
        chk("rclke", {31'h0, RCLKE}, 32'h1);
        re_cnt++;
      end
      if (poke && k == 2) begin
        START = 1'b1; BASE = 8'h40; LEN = 9'd5;
      end else begin
        START = 1'b0;
      end
      if (DONE) begin
        got = 1'b1;
        chk("busy_at_done", {31'h0, BUSY}, 32'h0);
      end
    end
    chk("done_seen", {31'h0, got}, 32'h1);
    if (exp_k >= 0) chk("done_latency", k, exp_k);
    chk("re_count", re_cnt, {23'h0, len});
    @(negedge CLK);
    chk("done_one_cycle", {31'h0, DONE}, 32'h0);
    chk("queue_drained", exp_q.size(), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    int p0;
    ASYNCRESETN = 1'b0;
    START = 1'b0;
    BASE = 8'h00;
    LEN = 9'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'h3C00;
    repeat (3) @(negedge CLK);
    chk_rst("reset");
    ASYNCRESETN = 1'b1;
    repeat (2) @(negedge CLK);
    chk_rst("post_reset");

    // Basic two-word burst.
    mem[0] = 16'h00FE; mem[1] = 16'h00FF;
    run_burst(8'd0, 9'd2, 5, 1'b0);

    // Address wrap 255 -> 0.
    mem[255] = 16'hAAAA; mem[0] = 16'h5555;
    run_burst(8'd255, 9'd2, 5, 1'b0);

    // Backpressure with READY pattern 1,0,0,1.
    for (int i = 0; i < 8; i++) mem[16 + i] = 16'h1000 + 16'(i);
    ready_mode = 1'b1;
    run_burst(8'd16, 9'd8, -1, 1'b0);
    ready_mode = 1'b0;

    // Empty burst.
    run_burst(8'd7, 9'd0, 1, 1'b0);

    // START while busy is ignored.
    for (int i = 0; i < 4; i++) mem[32 + i] = 16'hBEE0 + 16'(i);
    run_burst(8'd32, 9'd4, 7, 1'b1);

    // Reset after three of eight words.
    for (int i = 0; i < 8; i++) mem[64 + i] = 16'hC000 + 16'(i);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), mem[64 + i]});
    p0 = pops;
    @(posedge CLK); #1;
    BASE = 8'd64; LEN = 9'd8; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    k = 0;
    while (pops < p0 + 3 && k < 100) begin
      @(negedge CLK); #2;
      k++;
    end
    chk("rst_words_before", pops - p0, 32'd3);
    ASYNCRESETN = 1'b0;
    #1;
    chk_rst("midburst");
    exp_q.delete();
    repeat (2) @(negedge CLK);
    ASYNCRESETN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("no_done_after_rst", {31'h0, DONE}, 32'h0);
      chk("no_valid_after_rst", {31'h0, VALID}, 32'h0);
    end
    mem[0] = 16'h1357;
    run_burst(8'd0, 9'd1, 4, 1'b0);

    // Full-depth burst.
    for (int i = 0; i < 256; i++) mem[i] = {~8'(i), 8'(i)};
    run_burst(8'd0, 9'd256, 259, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
